// File: rtl/cp0_timer_unit_if.sv
// Pipeline <-> CP0 bus: mfc0/mtc0 access, M-stage exception inputs, interrupt lines
// and the flush request back to the pipeline.
interface cp0_timer_unit_if #(
    parameter int unsigned NUM_HWINT = 6
);
    logic [4:0]           rd_addr;
    logic [31:0]          rd_data;
    logic                 wr_en;
    logic [4:0]           wr_addr;
    logic [31:0]          wr_data;
    logic [31:0]          pc;
    logic                 bd_in;
    logic [4:0]           exc_code_in;
    logic [31:0]          badvaddr_in;
    logic [NUM_HWINT-1:0] hwint;
    logic                 eret;
    logic                 req;
    logic [31:0]          epc_out;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, pc, bd_in, exc_code_in,
               badvaddr_in, hwint, eret,
        input  rd_data, req, epc_out
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, pc, bd_in, exc_code_in,
               badvaddr_in, hwint, eret,
        output rd_data, req, epc_out
    );
endinterface

// File: rtl/cp0_timer_unit.sv
// M-stage coprocessor 0: SR/Cause/EPC/PRId/BadVAddr/Count/Compare, interrupt vs.
// exception arbitration and the single pipeline flush request.
module cp0_timer_unit #(
    parameter int unsigned NUM_HWINT = 6,
    parameter bit          TIMER_EN  = 1'b1,
    parameter logic [31:0] PRID_VAL  = 32'h2001_1006
) (
    input logic             clk,
    input logic             reset,
    cp0_timer_unit_if.slave bus
);
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_SR       = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;
    localparam logic [4:0] EXC_ADEL     = 5'd4;
    localparam logic [4:0] EXC_ADES     = 5'd5;

    logic [5:0]  im_q;
    logic        exl_q;
    logic        ie_q;
    logic        bd_q;
    logic [5:0]  ip_q;
    logic [4:0]  exc_code_q;
    logic [31:2] epc_q;
    logic [31:0] badvaddr_q;
    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic        ti_q;

    logic [5:0]  ip_vec;
    logic        int_req;
    logic        exc_req;
    logic        req;
    logic        mtc0_we;
    logic [31:0] epc_new;
    logic [31:0] rd_data;

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        ip_vec                 = '0;
        ip_vec[NUM_HWINT-1:0]  = bus.hwint;
        if (TIMER_EN) begin
            ip_vec[5] = ip_vec[5] | ti_q;
        end
    end

    assign int_req = (|(ip_vec & im_q)) & ~exl_q & ie_q;
    assign exc_req = (bus.exc_code_in != 5'd0) & ~exl_q;
    assign req     = int_req | exc_req;
    // A taken exception/interrupt swallows any mtc0 in the same cycle.
    assign mtc0_we = bus.wr_en & ~req;
    assign epc_new = bus.bd_in ? (bus.pc - 32'd4) : bus.pc;

    assign bus.req     = req;
    assign bus.epc_out = req ? epc_new : {epc_q, 2'b00};
    assign bus.rd_data = rd_data;

    // NOTE: synchronous reset placed first in the clocked block so it overrides
    // every other update, including an exception being taken that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_q       <= '0;
            exc_code_q <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so all state updates see the
            // pre-edge values, matching the combinational req/epc_new.
            ip_q <= ip_vec;
            if (req) begin
                exl_q      <= 1'b1;
                bd_q       <= bus.bd_in;
                exc_code_q <= int_req ? 5'd0 : bus.exc_code_in;
                epc_q      <= epc_new[31:2];
                if (!int_req && (bus.exc_code_in == EXC_ADEL || bus.exc_code_in == EXC_ADES)) begin
                    badvaddr_q <= bus.badvaddr_in;
                end
            end else begin
                if (mtc0_we) begin
                    case (bus.wr_addr)
                        REG_SR: begin
                            im_q  <= bus.wr_data[15:10];
                            exl_q <= bus.wr_data[1];
                            ie_q  <= bus.wr_data[0];
                        end
                        REG_EPC: epc_q <= bus.wr_data[31:2];
                        default: ;
                    endcase
                end
                if (bus.eret) begin
                    exl_q <= 1'b0;
                end
            end
        end
    end

    generate
        if (TIMER_EN) begin : g_timer
            always_ff @(posedge clk) begin
                if (reset) begin
                    count_q   <= '0;
                    compare_q <= '0;
                    ti_q      <= 1'b0;
                end else begin
                    count_q <= (mtc0_we && bus.wr_addr == REG_COUNT) ? bus.wr_data : count_q + 32'd1;
                    // Compare write acknowledges the timer and beats a coincident match.
                    if (mtc0_we && bus.wr_addr == REG_COMPARE) begin
                        compare_q <= bus.wr_data;
                        ti_q      <= 1'b0;
                    end else if (count_q == compare_q && compare_q != 32'd0) begin
                        ti_q <= 1'b1;
                    end
                end
            end
        end else begin : g_no_timer
            assign count_q   = '0;
            assign compare_q = '0;
            assign ti_q      = 1'b0;
        end
    endgenerate

    always_comb begin
        rd_data = '0;
        case (bus.rd_addr)
            REG_BADVADDR: rd_data = badvaddr_q;
            REG_COUNT:    rd_data = count_q;
            REG_COMPARE:  rd_data = compare_q;
            REG_SR:       rd_data = {16'd0, im_q, 8'd0, exl_q, ie_q};
            REG_CAUSE:    rd_data = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};
            REG_EPC:      rd_data = {epc_q, 2'b00};
            REG_PRID:     rd_data = PRID_VAL;
            default:      rd_data = '0;
        endcase
    end
endmodule

// File: tb/tb_cp0_timer_unit.sv
// Scoreboard bench for cp0_timer_unit: full config plus a NUM_HWINT=2 / TIMER_EN=0 copy.
module tb_cp0_timer_unit;
    logic clk = 1'b0;
    logic reset;
    always #10 clk = ~clk;

    cp0_timer_unit_if #(.NUM_HWINT(6)) bus ();
    cp0_timer_unit_if #(.NUM_HWINT(2)) bus2 ();

    cp0_timer_unit #(.NUM_HWINT(6), .TIMER_EN(1'b1), .PRID_VAL(32'h2001_1006)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    cp0_timer_unit #(.NUM_HWINT(2), .TIMER_EN(1'b0), .PRID_VAL(32'h2001_1006)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic quiet();
        bus.wr_en = 1'b0; bus.eret = 1'b0; bus.exc_code_in = 5'd0; bus.bd_in = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        bus.rd_addr = a; #1; d = bus.rd_data;
    endtask

    task automatic rd2(input logic [4:0] a, output logic [31:0] d);
        bus2.rd_addr = a; #1; d = bus2.rd_data;
    endtask

    task automatic test_reset();
        exp_t e; logic [31:0] o;
        reset = 1'b1;
        bus.exc_code_in = 5'd5; bus.bd_in = 1'b1; bus.pc = 32'h8888; bus.badvaddr_in = 32'h7777;
        mtc0(5'd12, 32'hFFFF_FFFF);
        sb.push_back('{"sr_reset", 32'h0});       sb.push_back('{"epc_reset", 32'h0});
        sb.push_back('{"badvaddr_reset", 32'h0}); sb.push_back('{"cause_reset", 32'h0});
        sb.push_back('{"count_reset", 32'h0});    sb.push_back('{"req_reset", 32'h0});
        sb.push_back('{"epc_out_reset", 32'h0});  sb.push_back('{"prid", 32'h2001_1006});
        @(negedge clk); @(negedge clk);
        quiet();
        rd(5'd12, o); e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        rd(5'd14, o); e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        rd(5'd8, o); e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        rd(5'd13, o); e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        rd(5'd9, o); e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        o = {31'd0, bus.req}; e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        o = bus.epc_out; e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        rd(5'd15, o); e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_mtc0_fields();
        exp_t e; logic [31:0] o;
        // Each cycle: issue one write, read back the previous cycle's register.
        logic [4:0]  w_addr[6] = '{5'd12, 5'd14, 5'd13, 5'd8, 5'd7, 5'd12};
        logic [31:0] w_data[6] = '{32'hFFFF_FFFF, 32'h1234_5677, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
        logic [4:0]  r_addr[6] = '{5'd12, 5'd14, 5'd14, 5'd13, 5'd8, 5'd7};
        logic [31:0] r_exp[6]  = '{32'h0, 32'h0, 32'h1234_5674, 32'h0, 32'h0, 32'h0};
        string       r_name[6] = '{"sr_no_bypass", "epc_no_bypass", "epc_low_bits", "cause_readonly", "badvaddr_readonly", "reg7_zero"};
        for (int i = 0; i < 6; i++) begin
            mtc0(w_addr[i], w_data[i]);
            sb.push_back('{r_name[i], r_exp[i]});
            rd(r_addr[i], o); e = sb.pop_front(); n_total++;
            if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
            if (i == 1) begin
                sb.push_back('{"sr_stored_bits", 32'h0000_FC03});
                rd(5'd12, o); e = sb.pop_front(); n_total++;
                if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
            end
            @(negedge clk);
        end
        quiet();
    endtask

    task automatic test_hwint_irq();
        exp_t e; logic [31:0] o;
        bus.pc = 32'h1000; bus.hwint = 6'b000100;
        mtc0(5'd12, 32'h0000_FC01);
        sb.push_back('{"irq_req_before_sr", 32'h0});
        #1 o = {31'd0, bus.req}; e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        @(negedge clk); quiet();
        sb.push_back('{"irq_req", 32'h1}); sb.push_back('{"irq_epc_out", 32'h1000});
        #1 o = {31'd0, bus.req}; e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        o = bus.epc_out; e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        @(negedge clk);
        sb.push_back('{"irq_req_while_exl", 32'h0}); sb.push_back('{"irq_sr", 32'h0000_FC03});
        sb.push_back('{"irq_cause", 32'h0000_1000}); sb.push_back('{"irq_epc", 32'h1000});
        #1 o = {31'd0, bus.req}; e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        rd(5'd12, o); e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        rd(5'd13, o); e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        rd(5'd14, o); e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        bus.eret = 1'b1;
        @(negedge clk); quiet();
        // Level still held: fires again as soon as eret has cleared EXL.
        sb.push_back('{"irq_refire_after_eret", 32'h1});
        #1 o = {31'd0, bus.req}; e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        bus.hwint = 6'b000000;
        @(negedge clk);
    endtask

    task automatic test_adel_bd();
        exp_t e; logic [31:0] o;
        bus.exc_code_in = 5'd4; bus.bd_in = 1'b1; bus.pc = 32'h3008; bus.badvaddr_in = 32'h1001;
        sb.push_back('{"adel_req", 32'h1}); sb.push_back('{"adel_epc_out", 32'h3004});
        #1 o = {31'd0, bus.req}; e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        o = bus.epc_out; e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        @(negedge clk); quiet();
        sb.push_back('{"adel_cause", 32'h8000_0010}); sb.push_back('{"adel_badvaddr", 32'h1001});
        sb.push_back('{"adel_epc", 32'h3004});
        rd(5'd13, o); e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        rd(5'd8, o); e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        rd(5'd14, o); e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        bus.eret = 1'b1;
        @(negedge clk); quiet();
    endtask

    task automatic test_int_priority();
        exp_t e; logic [31:0] o;
        bus.hwint = 6'b000001; bus.exc_code_in = 5'd12; bus.pc = 32'h4000; bus.badvaddr_in = 32'h9999;
        mtc0(5'd14, 32'hDEAD_0000);
        sb.push_back('{"prio_req", 32'h1}); sb.push_back('{"prio_epc_out", 32'h4000});
        #1 o = {31'd0, bus.req}; e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        o = bus.epc_out; e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        @(negedge clk); quiet(); bus.hwint = 6'b000000;
        sb.push_back('{"prio_cause", 32'h0000_0400}); sb.push_back('{"prio_epc_mtc0_dropped", 32'h4000});
        sb.push_back('{"prio_badvaddr_kept", 32'h1001});
        rd(5'd13, o); e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        rd(5'd14, o); e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        rd(5'd8, o); e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        bus.eret = 1'b1;
        @(negedge clk); quiet();
    endtask

    task automatic test_timer();
        exp_t e; logic [31:0] o;
        mtc0(5'd9, 32'hFFFF_FFFE);
        @(negedge clk); mtc0(5'd11, 32'd3);
        sb.push_back('{"count_load", 32'hFFFF_FFFE});
        rd(5'd9, o); e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        @(negedge clk); quiet();
        sb.push_back('{"count_max", 32'hFFFF_FFFF}); sb.push_back('{"compare_val", 32'd3});
        rd(5'd9, o); e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        rd(5'd11, o); e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        @(negedge clk);
        sb.push_back('{"count_wrap", 32'h0});
        rd(5'd9, o); e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        repeat (3) @(negedge clk);
        sb.push_back('{"timer_count_at_match", 32'd3}); sb.push_back('{"timer_req_at_match", 32'h0});
        rd(5'd9, o); e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        o = {31'd0, bus.req}; e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        @(negedge clk); bus.pc = 32'h5000;
        sb.push_back('{"timer_req", 32'h1}); sb.push_back('{"timer_epc_out", 32'h5000});
        #1 o = {31'd0, bus.req}; e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        o = bus.epc_out; e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        @(negedge clk);
        sb.push_back('{"timer_cause_ip7", 32'h0000_8000}); sb.push_back('{"timer_sr_exl", 32'h0000_FC03});
        rd(5'd13, o); e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        rd(5'd12, o); e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        mtc0(5'd11, 32'd0);
        @(negedge clk); quiet();
        @(negedge clk);
        sb.push_back('{"timer_ti_cleared", 32'h0});
        rd(5'd13, o); e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
    endtask

    task automatic test_eret_exc();
        exp_t e; logic [31:0] o;
        bus.eret = 1'b1; bus.exc_code_in = 5'd10; bus.pc = 32'h6000;
        sb.push_back('{"eret_exc_req_while_exl", 32'h0});
        #1 o = {31'd0, bus.req}; e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        @(negedge clk); bus.eret = 1'b0;
        sb.push_back('{"eret_sr", 32'h0000_FC01}); sb.push_back('{"exc10_req", 32'h1});
        sb.push_back('{"exc10_epc_out", 32'h6000});
        rd(5'd12, o); e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        o = {31'd0, bus.req}; e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        o = bus.epc_out; e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        @(negedge clk); quiet();
        sb.push_back('{"exc10_cause", 32'h0000_0028}); sb.push_back('{"exc10_badvaddr_kept", 32'h1001});
        rd(5'd13, o); e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        rd(5'd8, o); e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        bus.eret = 1'b1;
        @(negedge clk);
        // eret and a new exception together with EXL clear: the exception wins.
        bus.exc_code_in = 5'd5; bus.pc = 32'h7000; bus.badvaddr_in = 32'h2468;
        sb.push_back('{"eret_vs_req", 32'h1});
        #1 o = {31'd0, bus.req}; e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        @(negedge clk); quiet();
        sb.push_back('{"ades_sr_exl", 32'h0000_FC03}); sb.push_back('{"ades_badvaddr", 32'h2468});
        sb.push_back('{"ades_cause", 32'h0000_0014});
        rd(5'd12, o); e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        rd(5'd8, o); e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        rd(5'd13, o); e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        bus.eret = 1'b1;
        @(negedge clk); quiet();
    endtask

    task automatic test_param_variant();
        exp_t e; logic [31:0] o;
        bus2.wr_en = 1'b1; bus2.wr_addr = 5'd9; bus2.wr_data = 32'h55;
        @(negedge clk);
        bus2.wr_addr = 5'd11; bus2.wr_data = 32'h66; bus2.hwint = 2'b11;
        sb.push_back('{"notimer_count", 32'h0});
        rd2(5'd9, o); e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        @(negedge clk); bus2.wr_en = 1'b0;
        sb.push_back('{"notimer_compare", 32'h0}); sb.push_back('{"hw2_cause_ip", 32'h0000_0C00});
        sb.push_back('{"hw2_reg7", 32'h0});         sb.push_back('{"hw2_req_ie_off", 32'h0});
        rd2(5'd11, o); e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        rd2(5'd13, o); e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        rd2(5'd7, o); e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        o = {31'd0, bus2.req}; e = sb.pop_front(); n_total++;
        if (o !== e.val) $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, o, e.val); else n_pass++;
        bus2.hwint = 2'b00;
    endtask

    initial begin
        bus.rd_addr = 5'd0; bus.wr_en = 1'b0; bus.wr_addr = 5'd0; bus.wr_data = 32'd0;
        bus.pc = 32'd0; bus.bd_in = 1'b0; bus.exc_code_in = 5'd0; bus.badvaddr_in = 32'd0;
        bus.hwint = '0; bus.eret = 1'b0;
        bus2.rd_addr = 5'd0; bus2.wr_en = 1'b0; bus2.wr_addr = 5'd0; bus2.wr_data = 32'd0;
        bus2.pc = 32'd0; bus2.bd_in = 1'b0; bus2.exc_code_in = 5'd0; bus2.badvaddr_in = 32'd0;
        bus2.hwint = '0; bus2.eret = 1'b0;
        test_reset();
        test_mtc0_fields();
        test_hwint_irq();
        test_adel_bd();
        test_int_priority();
        test_timer();
        test_eret_exc();
        test_param_variant();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
